mont_mult_param: RTL and testbench



---
 rtl/mont_mult_param_if.sv | 24 ++
 rtl/mont_mult_param.sv | 115 +++++++++++
 tb/tb_mont_mult_param.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mont_mult_param_if.sv
// Operand/result bundle for the bit-serial Montgomery multiplier.
// master drives the request side, slave is the multiplier.
interface mont_mult_param_if #(
    parameter int WIDTH = 192
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] z;
    logic             done;
    logic             busy;
    logic             err;

    modport master (
        output start, x, y, m,
        input  z, done, busy, err
    );

    modport slave (
        input  start, x, y, m,
        output z, done, busy, err
    );
endinterface

// File: rtl/mont_mult_param.sv
// Radix-2 bit-serial Montgomery multiplier: z = x*y*2^(-WIDTH) mod m, odd m.
// One iteration per clock; fixed latency of WIDTH+2 cycles from start to done.
module mont_mult_param #(
    parameter int WIDTH = 192,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic              clk,
    input logic              reset,
    mont_mult_param_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        SUB,
        FIN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] y_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH+1:0] s;
    logic [CNT_W-1:0] cnt;
    logic             err_pend;

    logic [WIDTH-1:0] z_r;
    logic             done_r;
    logic             busy_r;
    logic             err_r;

    logic [WIDTH+1:0] t_add;
    logic [WIDTH+1:0] t_red;
    logic [WIDTH+1:0] s_diff;
    logic [WIDTH+1:0] m_ext;

    assign bus.z    = z_r;
    assign bus.done = done_r;
    assign bus.busy = busy_r;
    assign bus.err  = err_r;

    // x is shifted out LSB-first so iteration i always looks at x_sh[0].
    always_comb begin
        m_ext  = {2'b00, m_reg};
        t_add  = s + (x_sh[0] ? {2'b00, y_reg} : '0);
        t_red  = t_add[0] ? (t_add + m_ext) : t_add;
        s_diff = s - m_ext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            x_sh     <= '0;
            y_reg    <= '0;
            m_reg    <= '0;
            s        <= '0;
            cnt      <= '0;
            err_pend <= 1'b0;
            z_r      <= '0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_sh     <= bus.x;
                        y_reg    <= bus.y;
                        m_reg    <= bus.m;
                        s        <= '0;
                        cnt      <= '0;
                        busy_r   <= 1'b1;
                        err_pend <= ~bus.m[0];
                        // Even modulus borrows the SUB slot so done/err are
                        // registered on entry to FIN, giving the 2-cycle path.
                        state    <= bus.m[0] ? ITER : SUB;
                    end
                end

                ITER: begin
                    s    <= t_red >> 1;
                    x_sh <= x_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= SUB;
                    end
                end

                SUB: begin
                    if (err_pend) begin
                        z_r <= '0;
                    end else if (s >= m_ext) begin
                        z_r <= s_diff[WIDTH-1:0];
                    end else begin
                        z_r <= s[WIDTH-1:0];
                    end
                    done_r <= 1'b1;
                    err_r  <= err_pend;
                    busy_r <= 1'b0;
                    state  <= FIN;
                end

                FIN: begin
                    err_pend <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mult_param.sv
// Directed bench for mont_mult_param: an 8-bit instance for most scenarios and
// a 192-bit instance for the full-width case.
module tb_mont_mult_param;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mont_mult_param_if #(.WIDTH(8))   b8 ();
    mont_mult_param_if #(.WIDTH(192)) b192 ();

    mont_mult_param #(.WIDTH(8)) u8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8)
    );

    mont_mult_param #(.WIDTH(192)) u192 (
        .clk   (clk),
        .reset (reset),
        .bus   (b192)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    // Independent reference: the unique r < mod with r*256 == x*y (mod mod).
    function automatic int unsigned mont_ref(input int unsigned a, input int unsigned b,
                                             input int unsigned mod);
        int unsigned p;
        p = (a * b) % mod;
        for (int unsigned r = 0; r < mod; r++) begin
            if (((r * 256) % mod) == p) return r;
        end
        return 32'hFFFF_FFFF;
    endfunction

    // Runs one 8-bit operation; lat counts cycles from start to done (-1 on timeout).
    task automatic run8(input logic [7:0] xi, input logic [7:0] yi, input logic [7:0] mi,
                        output logic [7:0] zo, output int lat, output logic eo,
                        output int bcnt, output logic dnext);
        @(negedge clk);
        b8.x = xi; b8.y = yi; b8.m = mi; b8.start = 1'b1;
        @(posedge clk); #1;
        lat  = 1;
        bcnt = int'(b8.busy);
        @(negedge clk);
        b8.start = 1'b0;
        while (!b8.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            bcnt += int'(b8.busy);
        end
        if (!b8.done) lat = -1;
        zo = b8.z;
        eo = b8.err;
        @(posedge clk); #1;
        dnext = b8.done;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        b8.start = 1'b0; b8.x = '0; b8.y = '0; b8.m = '0;
        b192.start = 1'b0; b192.x = '0; b192.y = '0; b192.m = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({b8.z, b8.done, b8.busy, b8.err} !== 11'd0) begin
            errors++;
            $display("FAIL reset8: got z=%0d done=%b busy=%b err=%b, want all 0",
                     b8.z, b8.done, b8.busy, b8.err);
        end
        checks++;
        if (b192.z !== 192'd0 || b192.done !== 1'b0 || b192.busy !== 1'b0 || b192.err !== 1'b0) begin
            errors++;
            $display("FAIL reset192: got z=%0h done=%b busy=%b err=%b, want all 0",
                     b192.z, b192.done, b192.busy, b192.err);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        logic [7:0] z; int lat; logic e; int bc; logic dn;
        run8(8'd5, 8'd7, 8'd251, z, lat, e, bc, dn);
        checks++; if (z !== 8'd7)  begin errors++; $display("FAIL basic_z: got %0d want 7", z); end
        checks++; if (lat !== 10)  begin errors++; $display("FAIL basic_lat: got %0d want 10", lat); end
        checks++; if (e !== 1'b0)  begin errors++; $display("FAIL basic_err: got %b want 0", e); end
        checks++; if (bc !== 9)    begin errors++; $display("FAIL basic_busy: got %0d want 9", bc); end
        checks++; if (dn !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", dn); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] xs [3] = '{8'd1, 8'd250, 8'd0};
        logic [7:0] ys [3] = '{8'd1, 8'd250, 8'd99};
        logic [7:0] zs [3] = '{8'd201, 8'd201, 8'd0};
        int   seen   = 0;
        int   last_t = -1;
        logic prev_done = 1'b0;
        @(negedge clk);
        b8.m = 8'd251; b8.x = xs[0]; b8.y = ys[0]; b8.start = 1'b1;
        for (int t = 0; t < 80 && seen < 3; t++) begin
            @(posedge clk); #1;
            if (prev_done) begin
                checks++;
                if (b8.done !== 1'b0) begin
                    errors++; $display("FAIL b2b_done_width: got %b want 0 at t=%0d", b8.done, t);
                end
            end
            prev_done = b8.done;
            if (b8.done) begin
                checks++;
                if (b8.z !== zs[seen]) begin
                    errors++; $display("FAIL b2b_z%0d: got %0d want %0d", seen, b8.z, zs[seen]);
                end
                if (seen > 0) begin
                    checks++;
                    if (t - last_t !== 11) begin
                        errors++; $display("FAIL b2b_period%0d: got %0d want 11", seen, t - last_t);
                    end
                end
                last_t = t;
                seen++;
                @(negedge clk);
                if (seen < 3) begin
                    b8.x = xs[seen]; b8.y = ys[seen];
                end else begin
                    b8.start = 1'b0;
                end
            end
        end
        checks++;
        if (seen !== 3) begin errors++; $display("FAIL b2b_count: got %0d results want 3", seen); end
        @(posedge clk); #1;
        checks++;
        if (b8.done !== 1'b0) begin errors++; $display("FAIL b2b_last_width: got %b want 0", b8.done); end
    endtask

    task automatic test_wide;
        int lat = 1;
        @(negedge clk);
        b192.m = '1; b192.x = 192'd48; b192.y = 192'd2; b192.start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        b192.start = 1'b0;
        while (!b192.done && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!b192.done) lat = -1;
        checks++; if (b192.z !== 192'd96) begin errors++; $display("FAIL wide_z: got %0h want 60", b192.z); end
        checks++; if (lat !== 194) begin errors++; $display("FAIL wide_lat: got %0d want 194", lat); end
        checks++; if (b192.err !== 1'b0) begin errors++; $display("FAIL wide_err: got %b want 0", b192.err); end
    endtask

    task automatic test_even_modulus;
        logic [7:0] z; int lat; logic e; int bc; logic dn;
        run8(8'd1, 8'd1, 8'd251, z, lat, e, bc, dn);
        checks++; if (z !== 8'd201) begin errors++; $display("FAIL even_pre_z: got %0d want 201", z); end
        run8(8'd3, 8'd4, 8'd250, z, lat, e, bc, dn);
        checks++; if (lat !== 2)    begin errors++; $display("FAIL even_lat: got %0d want 2", lat); end
        checks++; if (e !== 1'b1)   begin errors++; $display("FAIL even_err: got %b want 1", e); end
        checks++; if (z !== 8'd0)   begin errors++; $display("FAIL even_z: got %0d want 0", z); end
        checks++; if (bc !== 1)     begin errors++; $display("FAIL even_busy: got %0d want 1", bc); end
        checks++; if (dn !== 1'b0)  begin errors++; $display("FAIL even_done_width: got %b want 0", dn); end
        checks++; if (b8.err !== 1'b0) begin errors++; $display("FAIL even_err_width: got %b want 0", b8.err); end
        run8(8'd5, 8'd7, 8'd251, z, lat, e, bc, dn);
        checks++; if (z !== 8'd7)   begin errors++; $display("FAIL even_post_z: got %0d want 7", z); end
        checks++; if (e !== 1'b0)   begin errors++; $display("FAIL even_post_err: got %b want 0", e); end
    endtask

    task automatic test_start_while_busy_and_abort;
        logic [7:0] z; int lat; logic e; int bc; logic dn;
        int n;
        int done_seen;
        // Second start mid-operation with different operands must be ignored.
        @(negedge clk);
        b8.m = 8'd251; b8.x = 8'd5; b8.y = 8'd7; b8.start = 1'b1;
        @(posedge clk); #1;
        n = 1;
        @(negedge clk); b8.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; n++; end
        @(negedge clk); b8.start = 1'b1; b8.x = 8'd1; b8.y = 8'd1;
        @(posedge clk); #1; n++;
        @(negedge clk); b8.start = 1'b0;
        while (!b8.done && n < 40) begin @(posedge clk); #1; n++; end
        if (!b8.done) n = -1;
        checks++; if (b8.z !== 8'd7) begin errors++; $display("FAIL busy_start_z: got %0d want 7", b8.z); end
        checks++; if (n !== 10)      begin errors++; $display("FAIL busy_start_lat: got %0d want 10", n); end
        repeat (2) @(posedge clk);
        // Reset in the middle of an operation aborts it without a done pulse.
        @(negedge clk);
        b8.x = 8'd5; b8.y = 8'd7; b8.start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); b8.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (b8.z !== 8'd0)    begin errors++; $display("FAIL abort_z: got %0d want 0", b8.z); end
        checks++; if (b8.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", b8.busy); end
        checks++; if (b8.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", b8.done); end
        @(negedge clk); reset = 1'b0;
        done_seen = 0;
        repeat (20) begin @(posedge clk); #1; done_seen += int'(b8.done); end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); end
        run8(8'd250, 8'd250, 8'd251, z, lat, e, bc, dn);
        checks++; if (z !== 8'd201) begin errors++; $display("FAIL abort_next_z: got %0d want 201", z); end
    endtask

    task automatic test_sweep;
        logic [7:0] z; int lat; logic e; int bc; logic dn;
        int unsigned xv, yv, want;
        for (int unsigned mm = 3; mm <= 255; mm += 2) begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (k == 1) begin
                    xv = mm - 1; yv = mm - 1;
                end else begin
                    xv = $urandom_range(mm - 1, 0);
                    yv = $urandom_range(mm - 1, 0);
                end
                want = mont_ref(xv, yv, mm);
                run8(xv[7:0], yv[7:0], mm[7:0], z, lat, e, bc, dn);
                checks++;
                if ({24'd0, z} !== want || lat !== 10) begin
                    errors++;
                    $display("FAIL sweep m=%0d x=%0d y=%0d: got z=%0d lat=%0d, want z=%0d lat=10",
                             mm, xv, yv, z, lat, want);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_wide;
        test_even_modulus;
        test_start_while_busy_and_abort;
        test_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
